// File: rtl/hdmi_island_packet_serializer.sv
// hdmi_island_packet_serializer: turns one buffered data-island packet into 32 TERC4 nibble
// triplets with on-the-fly BCH parity, chaining packets back to back within one island.
module hdmi_island_packet_serializer #(
    parameter logic [7:0] PARITY_POLY      = 8'h83,
    parameter bit         NULL_ON_UNDERRUN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pkt_valid,
    output logic         pkt_ready,
    input  logic [23:0]  hb,
    input  logic [223:0] pb,
    input  logic         send,
    input  logic         first,
    input  logic         hsync,
    input  logic         vsync,
    output logic [11:0]  aux_data,
    output logic         aux_valid,
    output logic         aux_last,
    output logic         underrun
);
    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t           state, state_n;
    logic [4:0]       k, j;
    logic [23:0]      buf_hb, hb_sh, src_hb, hb_n;
    logic [3:0][55:0] buf_sp, sp_sh, src_sp, sp_n;
    logic [7:0]       hecc, src_hecc, hecc_n;
    logic [3:0][7:0]  secc, src_secc, secc_n;
    logic [3:0]       ch0, ch1, ch2;
    logic             accept, emit, hs;

    function automatic logic [7:0] step(input logic [7:0] e, input logic b);
        return (e >> 1) ^ ((e[0] ^ b) ? PARITY_POLY : 8'h00);
    endfunction

    // On accept the character is built straight from the buffer (or zeros) with ECC cleared,
    // otherwise from the shift engine; j is the index of the character being produced.
    always_comb begin
        accept   = send && (state == S_IDLE || k == 5'd31);
        emit     = accept ? (!pkt_ready || NULL_ON_UNDERRUN) : (state == S_SEND && k != 5'd31);
        j        = accept ? 5'd0 : k + 5'd1;
        hs       = pkt_valid && pkt_ready;
        src_hb   = accept ? (pkt_ready ? 24'h0 : buf_hb) : hb_sh;
        src_hecc = accept ? 8'h00 : hecc;
        hb_n     = src_hb >> 1;
        hecc_n   = j < 5'd24 ? step(src_hecc, src_hb[0]) : src_hecc >> 1;
        ch0      = {~(accept & first), j < 5'd24 ? src_hb[0] : src_hecc[0], vsync, hsync};
        for (int i = 0; i < 4; i++) begin
            src_sp[i]   = accept ? (pkt_ready ? 56'h0 : buf_sp[i]) : sp_sh[i];
            src_secc[i] = accept ? 8'h00 : secc[i];
            sp_n[i]     = src_sp[i] >> 2;
            secc_n[i]   = j < 5'd28 ? step(step(src_secc[i], src_sp[i][0]), src_sp[i][1])
                                    : src_secc[i] >> 2;
            ch1[i]      = j < 5'd28 ? src_sp[i][0] : src_secc[i][0];
            ch2[i]      = j < 5'd28 ? src_sp[i][1] : src_secc[i][1];
        end
        state_n  = emit ? S_SEND : S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_ready <= 1'b1;
            buf_hb    <= 24'h0;
            buf_sp    <= '0;
            hb_sh     <= 24'h0;
            sp_sh     <= '0;
            hecc      <= 8'h00;
            secc      <= '0;
            k         <= 5'd0;
            aux_data  <= 12'h00C;
            aux_valid <= 1'b0;
            aux_last  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            pkt_ready <= ~hs & (accept | pkt_ready);
            if (hs) begin
                buf_hb <= hb;
                buf_sp <= pb;
            end
            if (emit) begin
                hb_sh <= hb_n;
                sp_sh <= sp_n;
                hecc  <= hecc_n;
                secc  <= secc_n;
            end
            k         <= emit ? j : 5'd0;
            aux_data  <= emit ? {ch2, ch1, ch0} : {8'h00, 2'b11, vsync, hsync};
            aux_valid <= emit;
            aux_last  <= emit && j == 5'd31;
            underrun  <= accept && pkt_ready;
        end
    end
endmodule

// File: tb/tb_hdmi_island_packet_serializer.sv
// tb_hdmi_island_packet_serializer: directed checks of packet serialization, parity, chaining,
// async reset and underrun handling for both null-packet settings.
module tb_hdmi_island_packet_serializer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pkt_valid = 1'b0, send = 1'b0, first = 1'b0, hsync = 1'b0, vsync = 1'b0;
    logic [23:0]  hb = 24'h0;
    logic [223:0] pb = '0;
    logic         pkt_ready, aux_valid, aux_last, underrun;
    logic [11:0]  aux_data;
    logic         pkt_ready_1, aux_valid_1, aux_last_1, underrun_1;
    logic [11:0]  aux_data_1;
    int           n_checks = 0, n_fail = 0;

    localparam logic [23:0]  HB_A = 24'hC3A55A;
    localparam logic [223:0] PB_A = {56'h0123456789ABCD, 56'hFEDCBA98765432,
                                     56'h00FF00FF00FF00, 56'h5A5A5A5A5A5A5A};
    localparam logic [23:0]  HB_B = 24'h0F0F81;
    localparam logic [223:0] PB_B = {56'hDEADBEEFCAFE12, 56'h13579BDF02468A,
                                     56'h80000000000001, 56'h7FFFFFFFFFFFFE};

    always #5 clk = ~clk;

    hdmi_island_packet_serializer #(.PARITY_POLY(8'h83), .NULL_ON_UNDERRUN(1'b1)) u0 (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .hb(hb), .pb(pb),
        .send(send), .first(first), .hsync(hsync), .vsync(vsync), .aux_data(aux_data),
        .aux_valid(aux_valid), .aux_last(aux_last), .underrun(underrun));

    hdmi_island_packet_serializer #(.PARITY_POLY(8'h83), .NULL_ON_UNDERRUN(1'b0)) u1 (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready_1), .hb(hb), .pb(pb),
        .send(send), .first(first), .hsync(hsync), .vsync(vsync), .aux_data(aux_data_1),
        .aux_valid(aux_valid_1), .aux_last(aux_last_1), .underrun(underrun_1));

    // BCH parity over the first n bits of d, consumed LSB first.
    function automatic logic [7:0] bch(input logic [55:0] d, input int n);
        logic [7:0] e;
        e = 8'h00;
        for (int i = 0; i < n; i++)
            e = {1'b0, e[7:1]} ^ ((e[0] ^ d[i]) ? 8'h83 : 8'h00);
        return e;
    endfunction

    function automatic logic [11:0] exp_char(input logic [23:0] h, input logic [223:0] p,
                                             input logic f, input int k, input logic hs,
                                             input logic vs);
        logic [7:0]  he, se;
        logic [55:0] sp;
        logic [3:0]  c0, c1, c2;
        he = bch({32'h0, h}, 24);
        c0 = {~(k == 0 && f), 1'b0, vs, hs};
        if (k < 24) c0[2] = h[k];
        else        c0[2] = he[k-24];
        for (int i = 0; i < 4; i++) begin
            sp = p[56*i +: 56];
            se = bch(sp, 56);
            if (k < 28) begin
                c1[i] = sp[2*k];
                c2[i] = sp[2*k+1];
            end else begin
                c1[i] = se[2*(k-28)];
                c2[i] = se[2*(k-28)+1];
            end
        end
        return {c2, c1, c0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        n_checks++;
        if ({pkt_ready, aux_valid, aux_last, underrun, aux_data} !== {4'b1000, 12'h00C}) begin
            n_fail++;
            $display("FAIL reset_u0: got rdy/val/last/und/data=%b%b%b%b/%h expected 1000/00c",
                     pkt_ready, aux_valid, aux_last, underrun, aux_data);
        end
        n_checks++;
        if ({pkt_ready_1, aux_valid_1, aux_last_1, underrun_1, aux_data_1} !== {4'b1000, 12'h00C}) begin
            n_fail++;
            $display("FAIL reset_u1: got rdy/val/last/und/data=%b%b%b%b/%h expected 1000/00c",
                     pkt_ready_1, aux_valid_1, aux_last_1, underrun_1, aux_data_1);
        end
        rst = 1'b0;
    endtask

    task automatic test_null_underrun;
        hsync = 1'b1;
        vsync = 1'b0;
        tick();
        n_checks++;
        if ({aux_valid, aux_data} !== {1'b0, 12'h00D}) begin
            n_fail++;
            $display("FAIL null_guard_idle: got val/data=%b/%h expected 0/00d", aux_valid, aux_data);
        end
        send = 1'b1;
        first = 1'b1;
        tick();
        send = 1'b0;
        first = 1'b0;
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if ({aux_valid, aux_last, underrun, aux_data} !==
                {1'b1, 1'(k == 31), 1'(k == 0), (k == 0) ? 12'h001 : 12'h009}) begin
                n_fail++;
                $display("FAIL null_char k=%0d: got val/last/und/data=%b%b%b/%h expected 1%b%b/%h",
                         k, aux_valid, aux_last, underrun, aux_data, k == 31, k == 0,
                         (k == 0) ? 12'h001 : 12'h009);
            end
            tick();
        end
        n_checks++;
        if ({aux_valid, aux_last, aux_data} !== {2'b00, 12'h00D}) begin
            n_fail++;
            $display("FAIL null_end: got val/last/data=%b%b/%h expected 00/00d",
                     aux_valid, aux_last, aux_data);
        end
    endtask

    task automatic test_packet(input string name, input logic [23:0] h, input logic [223:0] p);
        logic [11:0] exp;
        hb = h;
        pb = p;
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        n_checks++;
        if (pkt_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_loaded: got pkt_ready=%b expected 0", name, pkt_ready);
        end
        send = 1'b1;
        tick();
        send = 1'b0;
        n_checks++;
        if ({pkt_ready, underrun} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s_accept: got rdy/und=%b%b expected 10", name, pkt_ready, underrun);
        end
        for (int k = 0; k < 32; k++) begin
            exp = exp_char(h, p, 1'b0, k, hsync, vsync);
            n_checks++;
            if ({aux_valid, aux_last, aux_data} !== {1'b1, 1'(k == 31), exp}) begin
                n_fail++;
                $display("FAIL %s_char k=%0d: got val/last/data=%b%b/%h expected 1%b/%h",
                         name, k, aux_valid, aux_last, aux_data, k == 31, exp);
            end
            tick();
        end
        n_checks++;
        if (aux_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end: got aux_valid=%b expected 0", name, aux_valid);
        end
    endtask

    task automatic test_header;
        test_packet("header", 24'h000001, '0);
    endtask

    task automatic test_subpacket;
        test_packet("sp2", 24'h0, {56'h0, 56'hFFFFFFFFFFFFFF, 56'h0, 56'h0});
    endtask

    task automatic test_back_to_back;
        logic [11:0] exp;
        hsync = 1'b0;
        vsync = 1'b1;
        hb = HB_A;
        pb = PB_A;
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        send = 1'b1;
        first = 1'b1;
        tick();
        send = 1'b0;
        first = 1'b0;
        for (int n = 0; n < 64; n++) begin
            exp = (n < 32) ? exp_char(HB_A, PB_A, 1'b1, n, 1'b0, 1'b1)
                           : exp_char(HB_B, PB_B, 1'b0, n - 32, 1'b0, 1'b1);
            n_checks++;
            if ({aux_valid, aux_last, aux_data} !== {1'b1, 1'(n % 32 == 31), exp}) begin
                n_fail++;
                $display("FAIL b2b_char n=%0d: got val/last/data=%b%b/%h expected 1%b/%h",
                         n, aux_valid, aux_last, aux_data, n % 32 == 31, exp);
            end
            if (n == 3) begin
                hb = HB_B;
                pb = PB_B;
                pkt_valid = 1'b1;
            end
            if (n == 4) begin
                pkt_valid = 1'b0;
                n_checks++;
                if (pkt_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_buffered: got pkt_ready=%b expected 0", pkt_ready);
                end
            end
            if (n == 31) send = 1'b1;
            if (n == 32) begin
                send = 1'b0;
                n_checks++;
                if ({pkt_ready, underrun} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL b2b_chain: got rdy/und=%b%b expected 10", pkt_ready, underrun);
                end
            end
            tick();
        end
        n_checks++;
        if ({aux_valid, aux_data} !== {1'b0, 12'h00E}) begin
            n_fail++;
            $display("FAIL b2b_end: got val/data=%b/%h expected 0/00e", aux_valid, aux_data);
        end
        hsync = 1'b1;
        vsync = 1'b0;
    endtask

    task automatic test_reset_mid;
        hb = HB_A;
        pb = PB_A;
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        send = 1'b1;
        tick();
        send = 1'b0;
        for (int n = 0; n < 10; n++) begin
            pkt_valid = (n == 2);
            tick();
        end
        pkt_valid = 1'b0;
        n_checks++;
        if ({aux_valid, pkt_ready, aux_data} !== {2'b10, exp_char(HB_A, PB_A, 1'b0, 10, 1'b1, 1'b0)}) begin
            n_fail++;
            $display("FAIL rstmid_pre: got val/rdy/data=%b%b/%h expected 10/%h", aux_valid,
                     pkt_ready, aux_data, exp_char(HB_A, PB_A, 1'b0, 10, 1'b1, 1'b0));
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({aux_valid, aux_last, underrun, pkt_ready, aux_data} !== {4'b0001, 12'h00C}) begin
            n_fail++;
            $display("FAIL rstmid_async: got val/last/und/rdy/data=%b%b%b%b/%h expected 0001/00c",
                     aux_valid, aux_last, underrun, pkt_ready, aux_data);
        end
        rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({aux_valid, aux_data} !== {1'b0, 12'h00D}) begin
            n_fail++;
            $display("FAIL rstmid_resume: got val/data=%b/%h expected 0/00d", aux_valid, aux_data);
        end
        send = 1'b1;
        tick();
        send = 1'b0;
        n_checks++;
        if ({underrun, aux_valid, aux_data} !== {2'b11, 12'h009}) begin
            n_fail++;
            $display("FAIL rstmid_discard: got und/val/data=%b%b/%h expected 11/009",
                     underrun, aux_valid, aux_data);
        end
        for (int n = 0; n < 32; n++) tick();
    endtask

    task automatic test_no_null;
        logic [11:0] exp;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        send = 1'b1;
        tick();
        send = 1'b0;
        n_checks++;
        if ({underrun_1, aux_valid_1} !== 2'b10) begin
            n_fail++;
            $display("FAIL nonull_underrun: got und/val=%b%b expected 10", underrun_1, aux_valid_1);
        end
        tick();
        n_checks++;
        if ({underrun_1, aux_valid_1, aux_data_1} !== {2'b00, 12'h00D}) begin
            n_fail++;
            $display("FAIL nonull_idle: got und/val/data=%b%b/%h expected 00/00d",
                     underrun_1, aux_valid_1, aux_data_1);
        end
        hb = HB_B;
        pb = PB_B;
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        send = 1'b1;
        tick();
        send = 1'b0;
        for (int k = 0; k < 32; k++) begin
            exp = exp_char(HB_B, PB_B, 1'b0, k, 1'b1, 1'b0);
            n_checks++;
            if ({aux_valid_1, aux_last_1, underrun_1, aux_data_1} !== {1'b1, 1'(k == 31), 1'b0, exp}) begin
                n_fail++;
                $display("FAIL nonull_char k=%0d: got val/last/und/data=%b%b%b/%h expected 1%b0/%h",
                         k, aux_valid_1, aux_last_1, underrun_1, aux_data_1, k == 31, exp);
            end
            send = (k == 5);
            first = (k == 5);
            tick();
        end
        n_checks++;
        if (aux_valid_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL nonull_end: got aux_valid=%b expected 0", aux_valid_1);
        end
    endtask

    initial begin
        test_reset();
        test_null_underrun();
        test_header();
        test_subpacket();
        test_back_to_back();
        test_reset_mid();
        test_no_null();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
